// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the DTCM slave state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } dtcm_state_e;

  // Byte-lane enables for a legal (aligned, size <= word) transfer.
  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << lane;
      2'd1:    be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/tcm_sram.sv
// Single-port TCM storage: synchronous byte-enabled write, asynchronous read.
module tcm_sram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Commit only the enabled byte lanes; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dtcm_ahb_slave.sv
// AHB-Lite subordinate for the data TCM: address-phase capture, legality
// check, wait-state/error FSM and byte-enable generation around tcm_sram.
module dtcm_ahb_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [6:0]  hprot,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WS_LAST = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  dtcm_state_e      state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       lane_q, lane_d;
  logic [1:0]       size_q, size_d;
  logic             write_q, write_d;
  logic             hreadyout_q, hreadyout_d;
  logic             hresp_q, hresp_d;

  logic [31:0] offset;
  logic        addr_err, align_err, accept;
  logic        sram_we;
  logic [3:0]  sram_be;
  logic [31:0] sram_rdata;
  logic        unused_ok;

  // Bus attributes that do not affect a single TCM beat.
  assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0]};

  // Address-phase decode: acceptance and the illegal-access checks.
  always_comb begin
    offset    = haddr - BASE_ADDR;
    addr_err  = (haddr < BASE_ADDR) || (offset >= SPAN);
    align_err = (hsize > HSIZE_WORD) ||
                ((hsize == HSIZE_HALF) && haddr[0]) ||
                ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
    accept    = hsel && hready && htrans[1];
  end

  // Next-state logic; IDLE, DATA and ERR2 all share the same accept rule.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    size_d      = size_q;
    write_d     = write_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    case (state_q)
      ST_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d     = ST_DATA;
          hreadyout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d     = ST_ERR2;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_ERROR;
      end
      default: begin
        if (accept) begin
          idx_d   = offset[IDX_W+1:2];
          lane_d  = haddr[1:0];
          size_d  = hsize[1:0];
          write_d = hwrite;
          if (addr_err || align_err) begin
            state_d     = ST_ERR1;
            write_d     = 1'b0;
            hreadyout_d = 1'b0;
            hresp_d     = HRESP_ERROR;
          end else if (WAIT_STATES > 0) begin
            state_d     = ST_WAIT;
            wcnt_d      = WS_LAST;
            hreadyout_d = 1'b0;
            hresp_d     = HRESP_OKAY;
          end else begin
            state_d     = ST_DATA;
            hreadyout_d = 1'b1;
            hresp_d     = HRESP_OKAY;
          end
        end else begin
          state_d     = ST_IDLE;
          hreadyout_d = 1'b1;
          hresp_d     = HRESP_OKAY;
        end
      end
    endcase
  end

  // State, captured address phase and registered handshake outputs.
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= 4'd0;
      idx_q       <= '0;
      lane_q      <= 2'b00;
      size_q      <= 2'b00;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  assign sram_we   = (state_q == ST_DATA) && write_q;
  assign sram_be   = byte_enable(size_q, lane_q);
  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = (state_q == ST_DATA) ? sram_rdata : 32'h0;

  tcm_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_sram (
    .clk  (hclk),
    .addr (idx_q),
    .we   (sram_we),
    .be   (sram_be),
    .wdata(hwdata),
    .rdata(sram_rdata)
  );

endmodule

// File: tb/tb_dtcm_ahb_slave.sv
// Directed bench for dtcm_ahb_slave: three instances (0, 2 and 3 wait states)
// sharing one bus; dsel picks which one is selected and drives bus HREADY.
module tb_dtcm_ahb_slave;

  logic        hclk = 1'b0;
  logic        hrst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  int          dsel;

  logic        ro0, ro1, ro2, rs0, rs1, rs2;
  logic [31:0] rd0, rd1, rd2;
  logic        hready_m, hresp_m;
  logic [31:0] hrdata_m;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 hclk = ~hclk;

  assign hready_m = (dsel == 0) ? ro0 : (dsel == 1) ? ro1 : ro2;
  assign hresp_m  = (dsel == 0) ? rs0 : (dsel == 1) ? rs1 : rs2;
  assign hrdata_m = (dsel == 0) ? rd0 : (dsel == 1) ? rd1 : rd2;

  dtcm_ahb_slave #(.WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hrst(hrst), .hsel(hsel && dsel == 0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(3'b000), .hprot(7'h03), .hmastlock(1'b0),
    .hwdata(hwdata), .hready(hready_m), .hreadyout(ro0), .hresp(rs0), .hrdata(rd0));

  dtcm_ahb_slave #(.WAIT_STATES(2)) dut1 (
    .hclk(hclk), .hrst(hrst), .hsel(hsel && dsel == 1), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(3'b000), .hprot(7'h03), .hmastlock(1'b0),
    .hwdata(hwdata), .hready(hready_m), .hreadyout(ro1), .hresp(rs1), .hrdata(rd1));

  dtcm_ahb_slave #(.WAIT_STATES(3)) dut2 (
    .hclk(hclk), .hrst(hrst), .hsel(hsel && dsel == 2), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(3'b000), .hprot(7'h03), .hmastlock(1'b0),
    .hwdata(hwdata), .hready(hready_m), .hreadyout(ro2), .hresp(rs2), .hrdata(rd2));

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] addr, input logic [2:0] size);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
  endtask

  // One isolated transfer; reports data-phase result and count of stalled cycles.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic resp, output int low);
    addr_phase(wr, addr, size);
    tick();
    bus_idle();
    hwdata = wdata;
    low = 0;
    while (hready_m !== 1'b1 && low < 20) begin
      low++;
      tick();
    end
    rdata = hrdata_m;
    resp  = hresp_m;
    tick();
  endtask

  task automatic test_reset();
    hrst = 1'b1;
    bus_idle();
    haddr = 32'h0; hsize = 3'd2; hwdata = 32'h0; dsel = 0;
    tick();
    tick();
    tests_run++;
    if ({ro0, ro1, ro2} !== 3'b111) begin
      tests_failed++;
      $display("[TB] FAIL reset_hreadyout: got %b expected 111", {ro0, ro1, ro2});
    end
    tests_run++;
    if ({rs0, rs1, rs2} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_hresp: got %b expected 000", {rs0, rs1, rs2});
    end
    tests_run++;
    if ((rd0 | rd1 | rd2) !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_hrdata: got %h/%h/%h expected 0", rd0, rd1, rd2);
    end
    #2 hrst = 1'b0;
    tick();
  endtask

  task automatic test_word_rw();
    logic [31:0] rd; logic rs; int low;
    dsel = 0;
    do_xfer(1'b1, 32'h2000_0004, 3'd2, 32'hDEAD_BEEF, rd, rs, low);
    tests_run++;
    if (low !== 0 || rs !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL word_write: got low=%0d resp=%b expected low=0 resp=0", low, rs);
    end
    do_xfer(1'b0, 32'h2000_0004, 3'd2, 32'h0, rd, rs, low);
    tests_run++;
    if (rd !== 32'hDEAD_BEEF || rs !== 1'b0 || low !== 0) begin
      tests_failed++;
      $display("[TB] FAIL word_read: got %h resp=%b low=%0d expected deadbeef resp=0 low=0", rd, rs, low);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic rs; int low;
    dsel = 0;
    do_xfer(1'b1, 32'h2000_0004, 3'd2, 32'h1122_3344, rd, rs, low);
    do_xfer(1'b1, 32'h2000_0006, 3'd0, 32'h00A5_0000, rd, rs, low);
    do_xfer(1'b0, 32'h2000_0004, 3'd2, 32'h0, rd, rs, low);
    tests_run++;
    if (rd !== 32'h11A5_3344) begin
      tests_failed++;
      $display("[TB] FAIL byte_write: got %h expected 11a53344", rd);
    end
    do_xfer(1'b1, 32'h2000_0006, 3'd1, 32'hBEEF_0000, rd, rs, low);
    do_xfer(1'b1, 32'h2000_0004, 3'd0, 32'h0000_0077, rd, rs, low);
    do_xfer(1'b0, 32'h2000_0004, 3'd2, 32'h0, rd, rs, low);
    tests_run++;
    if (rd !== 32'hBEEF_3377) begin
      tests_failed++;
      $display("[TB] FAIL half_byte_write: got %h expected beef3377", rd);
    end
    do_xfer(1'b1, 32'h2000_0004, 3'd1, 32'h0000_5A5A, rd, rs, low);
    do_xfer(1'b0, 32'h2000_0004, 3'd2, 32'h0, rd, rs, low);
    tests_run++;
    if (rd !== 32'hBEEF_5A5A) begin
      tests_failed++;
      $display("[TB] FAIL low_half_write: got %h expected beef5a5a", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic rs; int low;
    dsel = 0;
    do_xfer(1'b1, 32'h2000_0010, 3'd2, 32'h0, rd, rs, low);
    addr_phase(1'b1, 32'h2000_0010, 3'd2);
    tick();
    hwdata = 32'hCAFE_F00D;
    addr_phase(1'b0, 32'h2000_0010, 3'd2);
    tests_run++;
    if (hready_m !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_write_ready: got %b expected 1", hready_m);
    end
    tick();
    bus_idle();
    hwdata = 32'h0;
    tests_run++;
    if (hrdata_m !== 32'hCAFE_F00D || hready_m !== 1'b1 || hresp_m !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_read: got %h ready=%b resp=%b expected cafef00d ready=1 resp=0",
               hrdata_m, hready_m, hresp_m);
    end
    tick();
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic rs; int low;
    dsel = 0;
    do_xfer(1'b1, 32'h2000_0000, 3'd2, 32'h55AA_55AA, rd, rs, low);
    addr_phase(1'b0, 32'h2000_0002, 3'd2);
    tick();
    bus_idle();
    tests_run++;
    if (hready_m !== 1'b0 || hresp_m !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_cycle1: got ready=%b resp=%b expected ready=0 resp=1", hready_m, hresp_m);
    end
    tick();
    tests_run++;
    if (hready_m !== 1'b1 || hresp_m !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_cycle2: got ready=%b resp=%b expected ready=1 resp=1", hready_m, hresp_m);
    end
    tick();
    do_xfer(1'b0, 32'h2000_0000, 3'd2, 32'h0, rd, rs, low);
    tests_run++;
    if (rd !== 32'h55AA_55AA || rs !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL after_err_read: got %h resp=%b expected 55aa55aa resp=0", rd, rs);
    end
    do_xfer(1'b0, 32'h2000_1000, 3'd2, 32'h0, rd, rs, low);
    tests_run++;
    if (low !== 1 || rs !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_range_hi: got low=%0d resp=%b expected low=1 resp=1", low, rs);
    end
    do_xfer(1'b0, 32'h1FFF_FFFC, 3'd2, 32'h0, rd, rs, low);
    tests_run++;
    if (low !== 1 || rs !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_range_lo: got low=%0d resp=%b expected low=1 resp=1", low, rs);
    end
    do_xfer(1'b1, 32'h2000_0001, 3'd1, 32'hFFFF_FFFF, rd, rs, low);
    tests_run++;
    if (low !== 1 || rs !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_half_odd: got low=%0d resp=%b expected low=1 resp=1", low, rs);
    end
    do_xfer(1'b1, 32'h2000_0000, 3'd3, 32'hFFFF_FFFF, rd, rs, low);
    tests_run++;
    if (low !== 1 || rs !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_size: got low=%0d resp=%b expected low=1 resp=1", low, rs);
    end
    do_xfer(1'b1, 32'h2000_0002, 3'd2, 32'hFFFF_FFFF, rd, rs, low);
    do_xfer(1'b0, 32'h2000_0000, 3'd2, 32'h0, rd, rs, low);
    tests_run++;
    if (rd !== 32'h55AA_55AA) begin
      tests_failed++;
      $display("[TB] FAIL err_no_write: got %h expected 55aa55aa", rd);
    end
    do_xfer(1'b1, 32'h2000_0FFC, 3'd2, 32'h600D_0FFC, rd, rs, low);
    do_xfer(1'b0, 32'h2000_0FFC, 3'd2, 32'h0, rd, rs, low);
    tests_run++;
    if (rd !== 32'h600D_0FFC || rs !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL last_word: got %h resp=%b expected 600d0ffc resp=0", rd, rs);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic rs; int low;
    dsel = 1;
    do_xfer(1'b1, 32'h2000_0004, 3'd2, 32'h0BAD_CAFE, rd, rs, low);
    tests_run++;
    if (low !== 2 || rs !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ws2_write: got low=%0d resp=%b expected low=2 resp=0", low, rs);
    end
    addr_phase(1'b0, 32'h2000_0004, 3'd2);
    tick();
    bus_idle();
    tests_run++;
    if (hready_m !== 1'b0 || hrdata_m !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL ws2_cycle1: got ready=%b data=%h expected ready=0 data=0", hready_m, hrdata_m);
    end
    tick();
    tests_run++;
    if (hready_m !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ws2_cycle2: got ready=%b expected 0", hready_m);
    end
    tick();
    tests_run++;
    if (hready_m !== 1'b1 || hrdata_m !== 32'h0BAD_CAFE || hresp_m !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ws2_cycle3: got ready=%b data=%h resp=%b expected ready=1 data=0badcafe resp=0",
               hready_m, hrdata_m, hresp_m);
    end
    tick();
    hsel = 1'b1; htrans = 2'b01; haddr = 32'h2000_0002; hsize = 3'd2;
    tick();
    tests_run++;
    if (hready_m !== 1'b1 || hresp_m !== 1'b0 || hrdata_m !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL busy_beat: got ready=%b resp=%b data=%h expected 1 0 0", hready_m, hresp_m, hrdata_m);
    end
    htrans = 2'b00;
    tick();
    tests_run++;
    if (hready_m !== 1'b1 || hresp_m !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_beat: got ready=%b resp=%b expected 1 0", hready_m, hresp_m);
    end
    hsel = 1'b0; htrans = 2'b10;
    tick();
    tests_run++;
    if (hready_m !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL unselected: got ready=%b expected 1", hready_m);
    end
    bus_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic rs; int low;
    dsel = 2;
    do_xfer(1'b1, 32'h2000_0008, 3'd2, 32'hA1B2_C3D4, rd, rs, low);
    tests_run++;
    if (low !== 3) begin
      tests_failed++;
      $display("[TB] FAIL ws3_write: got low=%0d expected 3", low);
    end
    addr_phase(1'b1, 32'h2000_0008, 3'd2);
    tick();
    bus_idle();
    hwdata = 32'h1234_5678;
    tick();
    tests_run++;
    if (hready_m !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ws3_in_wait: got ready=%b expected 0", hready_m);
    end
    hrst = 1'b1;
    #1;
    tests_run++;
    if (hready_m !== 1'b1 || hresp_m !== 1'b0 || hrdata_m !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got ready=%b resp=%b data=%h expected 1 0 0", hready_m, hresp_m, hrdata_m);
    end
    #2 hrst = 1'b0;
    tick();
    do_xfer(1'b0, 32'h2000_0008, 3'd2, 32'h0, rd, rs, low);
    tests_run++;
    if (rd !== 32'hA1B2_C3D4) begin
      tests_failed++;
      $display("[TB] FAIL write_discarded: got %h expected a1b2c3d4", rd);
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_back_to_back();
    test_errors();
    test_wait_states();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
